// File: rtl/cfg_dispatch_pkg.sv
// Shared types and helpers for the multi-channel configuration dispatcher.
package cfg_dispatch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RUN   = 2'd2
   } ch_state_e;

   // Channel index width keeps at least one code above CH_NUM-1 so out-of-range targets stay observable.
   function automatic int ch_idx_w(input int ch_num);
      return $clog2(ch_num + 1);
   endfunction

   // LSB position of channel ch inside the packed out_data bus.
   function automatic int data_slice(input int ch, input int cwidth);
      return ch * cwidth;
   endfunction

endpackage

// File: rtl/cfg_dispatch_if.sv
// Host word port plus per-engine start/busy bundle of the configuration dispatcher.
interface cfg_dispatch_if #(
   parameter int CH_NUM = 4,
   parameter int CWIDTH = 32
);
   import cfg_dispatch_pkg::*;

   localparam int CHW = ch_idx_w(CH_NUM);

   logic                       in_valid;
   logic                       in_ready;
   logic [CHW-1:0]             in_ch;
   logic [CWIDTH-1:0]          in_data;
   logic [CH_NUM-1:0]          out_valid;
   logic [CH_NUM*CWIDTH-1:0]   out_data;
   logic [CH_NUM-1:0]          eng_busy;

   modport master (
      output in_valid, in_ch, in_data, eng_busy,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_ch, in_data, eng_busy,
      output in_ready, out_valid, out_data
   );

endinterface

// File: rtl/cfg_chan_fifo.sv
// Per-channel configuration word queue with synchronous flush.
module cfg_chan_fifo #(
   parameter int DEPTH  = 4,
   parameter int CWIDTH = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_push,
   input  logic              i_pop,
   input  logic              i_flush,
   input  logic [CWIDTH-1:0] i_data,
   output logic              o_full,
   output logic              o_empty,
   output logic [CWIDTH-1:0] o_head
);
   localparam int          AW       = $clog2(DEPTH);
   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0] CNT_ZERO = {(AW+1){1'b0}};

   logic [CWIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_wr;
   logic [AW-1:0]     r_rd;
   logic [AW:0]       r_cnt;
   logic              w_push;
   logic              w_pop;

   assign o_full  = (r_cnt == CNT_FULL);
   assign o_empty = (r_cnt == CNT_ZERO);
   assign o_head  = r_mem[r_rd];
   // A push into a full queue is refused even when a pop lands on the same edge.
   assign w_push  = i_push && !i_flush && !o_full;
   assign w_pop   = i_pop && !i_flush && !o_empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr  <= {AW{1'b0}};
         r_rd  <= {AW{1'b0}};
         r_cnt <= CNT_ZERO;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= {CWIDTH{1'b0}};
         end
      end else if (i_flush) begin
         r_wr  <= {AW{1'b0}};
         r_rd  <= {AW{1'b0}};
         r_cnt <= CNT_ZERO;
      end else begin
         if (w_push) begin
            r_mem[r_wr] <= i_data;
            r_wr        <= r_wr + AW'(1);
         end
         if (w_pop) begin
            r_rd <= r_rd + AW'(1);
         end
         r_cnt <= r_cnt + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
      end
   end

endmodule

// File: rtl/cfg_dispatch.sv
// Multi-channel configuration dispatcher: per-channel queues and issue FSMs with
// independent or lockstep grant, feeding one-cycle start pulses to the engines.
module cfg_dispatch
   import cfg_dispatch_pkg::*;
#(
   parameter int CH_NUM = 4,
   parameter int CWIDTH = 32,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   cfg_dispatch_if.slave     bus,
   input  logic              i_lockstep,
   input  logic              i_flush,
   output logic [CH_NUM-1:0] o_ch_idle,
   output logic              o_err_ch,
   output logic [CNT_W-1:0]  o_issue_cnt
);
   localparam int CHW = ch_idx_w(CH_NUM);

   ch_state_e                r_state [CH_NUM];
   logic [CH_NUM-1:0]        r_out_valid;
   logic [CH_NUM*CWIDTH-1:0] r_out_data;
   logic [CNT_W-1:0]         r_issue_cnt;
   logic                     r_err_ch;

   logic [CH_NUM-1:0]        w_hit;
   logic [CH_NUM-1:0]        w_full;
   logic [CH_NUM-1:0]        w_empty;
   logic [CH_NUM-1:0]        w_push;
   logic [CH_NUM-1:0]        w_cand;
   logic [CH_NUM-1:0]        w_grant;
   logic [CWIDTH-1:0]        w_head [CH_NUM];
   logic                     w_ch_ok;
   logic                     w_in_ready;
   logic                     w_accept;
   logic [CNT_W-1:0]         w_n_grant;

   // Host port decode: out-of-range targets are always accepted and dropped.
   always_comb begin
      w_hit = {CH_NUM{1'b0}};
      for (int c = 0; c < CH_NUM; c++) begin
         w_hit[c] = (bus.in_ch == CHW'(c));
      end
      w_ch_ok    = |w_hit;
      w_in_ready = !i_flush && !(|(w_hit & w_full));
      w_accept   = bus.in_valid && w_in_ready;
      w_push     = w_accept ? w_hit : {CH_NUM{1'b0}};
   end

   // Grant evaluation; lockstep fires only when every channel is ready, flush cancels all.
   always_comb begin
      w_cand    = {CH_NUM{1'b0}};
      w_n_grant = {CNT_W{1'b0}};
      for (int c = 0; c < CH_NUM; c++) begin
         w_cand[c] = (r_state[c] == IDLE) && !w_empty[c] && !bus.eng_busy[c];
      end
      if (i_flush) begin
         w_grant = {CH_NUM{1'b0}};
      end else if (i_lockstep) begin
         w_grant = (&w_cand) ? {CH_NUM{1'b1}} : {CH_NUM{1'b0}};
      end else begin
         w_grant = w_cand;
      end
      for (int c = 0; c < CH_NUM; c++) begin
         w_n_grant = w_n_grant + CNT_W'(w_grant[c]);
      end
   end

   for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
      cfg_chan_fifo #(
         .DEPTH  (DEPTH),
         .CWIDTH (CWIDTH)
      ) u_fifo (
         .clk     (clk),
         .rst     (rst),
         .i_push  (w_push[g]),
         .i_pop   (w_grant[g]),
         .i_flush (i_flush),
         .i_data  (bus.in_data),
         .o_full  (w_full[g]),
         .o_empty (w_empty[g]),
         .o_head  (w_head[g])
      );
   end

   // Per-channel issue FSMs with registered start pulse and held data slice.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < CH_NUM; c++) begin
            r_state[c] <= IDLE;
         end
         r_out_valid <= {CH_NUM{1'b0}};
         r_out_data  <= {(CH_NUM*CWIDTH){1'b0}};
      end else begin
         r_out_valid <= w_grant;
         for (int c = 0; c < CH_NUM; c++) begin
            case (r_state[c])
               IDLE: begin
                  if (w_grant[c]) begin
                     r_state[c] <= ISSUE;
                     r_out_data[data_slice(c, CWIDTH) +: CWIDTH] <= w_head[c];
                  end
               end
               ISSUE: r_state[c] <= RUN;
               RUN: begin
                  if (!bus.eng_busy[c]) begin
                     r_state[c] <= IDLE;
                  end
               end
               default: r_state[c] <= IDLE;
            endcase
         end
      end
   end

   // Dispatch counter and sticky out-of-range flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_issue_cnt <= {CNT_W{1'b0}};
         r_err_ch    <= 1'b0;
      end else begin
         r_issue_cnt <= r_issue_cnt + w_n_grant;
         if (w_accept && !w_ch_ok) begin
            r_err_ch <= 1'b1;
         end
      end
   end

   always_comb begin
      o_ch_idle = {CH_NUM{1'b0}};
      for (int c = 0; c < CH_NUM; c++) begin
         o_ch_idle[c] = w_empty[c] && (r_state[c] == IDLE);
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign o_issue_cnt   = r_issue_cnt;
   assign o_err_ch      = r_err_ch;

endmodule

// File: tb/tb_cfg_dispatch.sv
// Directed and randomized checks of cfg_dispatch against a queue-based reference model.
module tb_cfg_dispatch;
   localparam int CHN  = 4;
   localparam int CW   = 32;
   localparam int DP   = 4;
   localparam int CNTW = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic            lockstep;
   logic            flush;
   logic [CHN-1:0]  ch_idle;
   logic            err_ch;
   logic [CNTW-1:0] issue_cnt;

   cfg_dispatch_if #(.CH_NUM(CHN), .CWIDTH(CW)) bus ();

   cfg_dispatch #(.CH_NUM(CHN), .CWIDTH(CW), .DEPTH(DP), .CNT_W(CNTW)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .i_lockstep  (lockstep),
      .i_flush     (flush),
      .o_ch_idle   (ch_idle),
      .o_err_ch    (err_ch),
      .o_issue_cnt (issue_cnt)
   );

   always #5 clk = ~clk;

   int          n_chk = 0;
   int          n_err = 0;
   int          cyc_n = 0;
   logic [31:0] mbuf [CHN][8];
   int          mhd [CHN];
   int          mcn [CHN];
   int          bl [CHN];
   int          lastp [CHN];
   int          pulses [CHN];
   int          exp_issued;
   logic        exp_err;
   logic [CHN-1:0] eb;
   logic [CHN-1:0] hold;
   logic [CHN-1:0] st;
   int          jl;
   logic        jl_rand;
   logic        last_acc;
   int          acc_n;
   int          pc [8];
   int          np;
   int          rel;
   int          p2;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic exp_ready();
      if (flush) return 1'b0;
      if (bus.in_ch >= 3'd4) return 1'b1;
      return (mcn[bus.in_ch[1:0]] < DP);
   endfunction

   task automatic model_clear();
      for (int c = 0; c < CHN; c++) begin
         mhd[c] = 0; mcn[c] = 0; bl[c] = 0; lastp[c] = -100; pulses[c] = 0;
      end
      eb = 4'h0; st = 4'h0; hold = 4'h0;
      exp_issued = 0; exp_err = 1'b0;
   endtask

   // One clock: check in_ready before the edge, then update the model and engines after it.
   task automatic cyc();
      logic        acc;
      logic        fl;
      logic [2:0]  ach;
      logic [31:0] adat;
      int          len;
      @(negedge clk);
      chk("in_ready", 128'(bus.in_ready), 128'(exp_ready()));
      acc = bus.in_valid && bus.in_ready;
      ach = bus.in_ch; adat = bus.in_data; fl = flush;
      last_acc = acc;
      if (acc) acc_n++;
      @(posedge clk); #1;
      cyc_n++;
      if (acc) begin
         if (ach < 3'd4) begin
            mbuf[ach[1:0]][(mhd[ach[1:0]] + mcn[ach[1:0]]) % 8] = adat;
            mcn[ach[1:0]]++;
            exp_issued++;
         end else begin
            exp_err = 1'b1;
         end
      end
      if (fl) begin
         for (int c = 0; c < CHN; c++) begin
            exp_issued -= mcn[c]; mcn[c] = 0;
         end
      end
      chk("err_ch", 128'(err_ch), 128'(exp_err));
      for (int c = 0; c < CHN; c++) begin
         if (bl[c] > 0) begin
            bl[c]--;
            if (bl[c] == 0) eb[c] = 1'b0;
         end
         if (st[c]) begin
            st[c] = 1'b0;
            len = jl_rand ? int'($urandom_range(0, 3)) : jl;
            if (len > 0) begin eb[c] = 1'b1; bl[c] = len; end
         end
         if (bus.out_valid[c]) begin
            st[c] = 1'b1;
            pulses[c]++;
            chk("pulse_has_word", 128'(mcn[c] > 0), 128'(1'b1));
            if (mcn[c] > 0) begin
               chk("out_data", 128'(bus.out_data[c*32 +: 32]), 128'(mbuf[c][mhd[c]]));
               mhd[c] = (mhd[c] + 1) % 8;
               mcn[c]--;
            end
            chk("issue_spacing", 128'((cyc_n - lastp[c]) >= 3), 128'(1'b1));
            lastp[c] = cyc_n;
         end
      end
      bus.eng_busy = eb | hold;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; lockstep = 1'b0; flush = 1'b0;
      bus.in_valid = 1'b0; bus.in_ch = 3'd0; bus.in_data = 32'h0; bus.eng_busy = 4'h0;
      jl = 3; jl_rand = 1'b0; last_acc = 1'b0; acc_n = 0;
      model_clear();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset values
      chk("rst_out_valid", 128'(bus.out_valid), 128'(4'h0));
      chk("rst_out_data", 128'(bus.out_data), 128'(0));
      chk("rst_issue_cnt", 128'(issue_cnt), 128'(16'd0));
      chk("rst_err_ch", 128'(err_ch), 128'(1'b0));
      chk("rst_ch_idle", 128'(ch_idle), 128'(4'hF));
      chk("rst_in_ready", 128'(bus.in_ready), 128'(1'b1));

      // Independent single word with a 3-cycle job
      bus.in_valid = 1'b1; bus.in_ch = 3'd0; bus.in_data = 32'hA5A5_0001;
      cyc();
      chk("t1_no_comb_path", 128'(bus.out_valid), 128'(4'h0));
      bus.in_valid = 1'b0;
      cyc();
      chk("t1_pulse", 128'(bus.out_valid), 128'(4'b0001));
      chk("t1_data", 128'(bus.out_data[31:0]), 128'(32'hA5A5_0001));
      chk("t1_cnt", 128'(issue_cnt), 128'(16'd1));
      cyc();
      chk("t1_one_cycle_pulse", 128'(bus.out_valid), 128'(4'h0));
      repeat (3) cyc();
      chk("t1_running", 128'(ch_idle[0]), 128'(1'b0));
      cyc();
      chk("t1_idle_after_busy", 128'(ch_idle[0]), 128'(1'b1));

      // Backpressure on ch1 while its engine is held busy
      jl = 0;
      hold = 4'b0010; bus.eng_busy = eb | hold;
      acc_n = 0;
      for (int i = 0; i < 5; i++) begin
         bus.in_valid = 1'b1; bus.in_ch = 3'd1; bus.in_data = 32'hB000_0000 + i;
         cyc();
      end
      bus.in_valid = 1'b0;
      chk("t2_accepted", 128'(acc_n), 128'(4));
      chk("t2_fifth_refused", 128'(last_acc), 128'(1'b0));
      chk("t2_no_issue_busy", 128'(pulses[1]), 128'(0));
      hold = 4'h0; bus.eng_busy = eb | hold;
      rel = cyc_n; np = 0;
      for (int i = 0; i < 20; i++) begin
         cyc();
         if (bus.out_valid[1] && np < 8) begin pc[np] = cyc_n; np++; end
      end
      chk("t2_issued", 128'(np), 128'(4));
      chk("t2_first", 128'(pc[0] - rel), 128'(1));
      chk("t2_gap1", 128'(pc[1] - pc[0]), 128'(3));
      chk("t2_gap2", 128'(pc[2] - pc[1]), 128'(3));
      chk("t2_gap3", 128'(pc[3] - pc[2]), 128'(3));
      chk("t2_cnt", 128'(issue_cnt), 128'(16'd5));

      // Lockstep: partial group waits, full group fires together
      lockstep = 1'b1; jl = 2;
      for (int i = 0; i < 3; i++) begin
         bus.in_valid = 1'b1; bus.in_ch = 3'(i); bus.in_data = 32'hC000_0000 + i;
         cyc();
      end
      bus.in_valid = 1'b0;
      np = 0;
      for (int i = 0; i < 5; i++) begin
         cyc();
         if (bus.out_valid != 4'h0) np++;
      end
      chk("t3_partial_waits", 128'(np), 128'(0));
      bus.in_valid = 1'b1; bus.in_ch = 3'd3; bus.in_data = 32'hC000_0003;
      cyc();
      bus.in_valid = 1'b0;
      chk("t3_not_yet", 128'(bus.out_valid), 128'(4'h0));
      cyc();
      chk("t3_all_fire", 128'(bus.out_valid), 128'(4'hF));
      chk("t3_cnt", 128'(issue_cnt), 128'(16'd9));
      for (int k = 0; k < 30 && (ch_idle != 4'hF || eb != 4'h0); k++) cyc();
      chk("t3_drain", 128'(ch_idle), 128'(4'hF));
      lockstep = 1'b0;

      // Flush while ch2 runs with three words queued
      jl = 8;
      bus.in_valid = 1'b1; bus.in_ch = 3'd2; bus.in_data = 32'hD000_0000;
      cyc();
      bus.in_valid = 1'b0;
      cyc();
      chk("t4_pulse", 128'(bus.out_valid), 128'(4'b0100));
      for (int i = 1; i < 4; i++) begin
         bus.in_valid = 1'b1; bus.in_ch = 3'd2; bus.in_data = 32'hD000_0000 + i;
         cyc();
      end
      bus.in_valid = 1'b0; flush = 1'b1;
      cyc();
      flush = 1'b0;
      chk("t4_run_kept", 128'(ch_idle[2]), 128'(1'b0));
      p2 = pulses[2];
      repeat (15) cyc();
      chk("t4_no_reissue", 128'(pulses[2]), 128'(p2));
      chk("t4_idle", 128'(ch_idle[2]), 128'(1'b1));
      chk("t4_cnt", 128'(issue_cnt), 128'(16'd10));

      // Out-of-range target is consumed and flagged
      bus.in_valid = 1'b1; bus.in_ch = 3'd5; bus.in_data = 32'hEEEE_0005;
      cyc();
      bus.in_valid = 1'b0;
      chk("t5_ready", 128'(last_acc), 128'(1'b1));
      chk("t5_err", 128'(err_ch), 128'(1'b1));
      repeat (3) cyc();
      chk("t5_dropped_cnt", 128'(issue_cnt), 128'(16'd10));
      chk("t5_idle", 128'(ch_idle), 128'(4'hF));

      // Randomized independent traffic with occasional flush
      jl_rand = 1'b1;
      for (int i = 0; i < 400; i++) begin
         bus.in_valid = 1'($urandom_range(0, 1));
         bus.in_ch    = 3'($urandom_range(0, 3));
         bus.in_data  = $urandom;
         flush        = ($urandom_range(0, 39) == 0);
         cyc();
      end
      bus.in_valid = 1'b0; flush = 1'b0;
      for (int k = 0; k < 100 && (ch_idle != 4'hF || eb != 4'h0); k++) cyc();
      chk("rnd_drain", 128'(ch_idle), 128'(4'hF));
      chk("rnd_cnt", 128'(issue_cnt), 128'(16'(exp_issued)));

      // Reset asserted while ch0 is in ISSUE
      jl_rand = 1'b0; jl = 3;
      bus.in_valid = 1'b1; bus.in_ch = 3'd0; bus.in_data = 32'hF000_0001;
      cyc();
      bus.in_valid = 1'b0;
      cyc();
      chk("t6_in_issue", 128'(bus.out_valid), 128'(4'b0001));
      rst = 1'b1;
      #1;
      chk("t6_out_valid", 128'(bus.out_valid), 128'(4'h0));
      chk("t6_out_data", 128'(bus.out_data), 128'(0));
      chk("t6_issue_cnt", 128'(issue_cnt), 128'(16'd0));
      chk("t6_err_ch", 128'(err_ch), 128'(1'b0));
      chk("t6_ch_idle", 128'(ch_idle), 128'(4'hF));
      chk("t6_in_ready", 128'(bus.in_ready), 128'(1'b1));
      model_clear();
      bus.eng_busy = 4'h0;
      @(posedge clk);
      #1 rst = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
